// File: rtl/sat_narrow_pkg.sv
// rtl/sat_narrow_pkg.sv - shared types, saturation bounds and parameter checks for sat_narrow
// Optional feature macro used by the top: SAT_NARROW_ROUND_EN
package sat_narrow_pkg;

  localparam int MAX_IN_W = 32;
  localparam int S1_W     = MAX_IN_W + 1;

  typedef logic signed [S1_W-1:0] s1_val_t;

  // Stage-1 result viewed at the widest supported width, sign-extended.
  typedef struct packed {
    logic    valid;
    s1_val_t value;
  } s1_payload_t;

  function automatic s1_val_t sat_max(input int w);
    s1_val_t one;
    one = s1_val_t'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic s1_val_t sat_min(input int w);
    s1_val_t one;
    one = s1_val_t'(1);
    return -(one <<< (w - 1));
  endfunction

  function automatic bit cfg_ok(input int in_w, input int out_w, input int shift, input int cnt_w);
    return (in_w >= 2) && (in_w <= MAX_IN_W) && (out_w >= 1) &&
           (shift >= 0) && (shift < in_w) && (out_w <= in_w - shift) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/sat_narrow_stage.sv
// rtl/sat_narrow_stage.sv - generic valid/ready pipeline register
// Loads whenever empty or downstream ready, so bubbles advance too.
module sat_narrow_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid_i,
  input  logic [W-1:0] s_tdata_i,
  output logic         s_tready_o,
  output logic         m_tvalid_o,
  output logic [W-1:0] m_tdata_o,
  input  logic         m_tready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign s_tready_o = !valid_q || m_tready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (s_tready_o) begin
      valid_d = s_tvalid_i;
      data_d  = s_tdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;

endmodule

// File: rtl/sat_narrow.sv
// rtl/sat_narrow.sv - streaming signed narrower: shift, saturate, sticky flag and event counter
// Optional: define SAT_NARROW_ROUND_EN for round-half-up before the shift (default is floor).
module sat_narrow
  import sat_narrow_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 0,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_sat,
  output logic                 sat_sticky,
  output logic [SAT_CNT_W-1:0] sat_count,
  input  logic                 clr
);

  if (!cfg_ok(IN_W, OUT_W, SHIFT, SAT_CNT_W)) begin : g_cfg_err
    $error("sat_narrow: unsupported IN_W=%0d OUT_W=%0d SHIFT=%0d SAT_CNT_W=%0d",
           IN_W, OUT_W, SHIFT, SAT_CNT_W);
  end

  localparam int S1_DW = IN_W + 1;
  localparam int S2_DW = OUT_W + 1;
  localparam s1_val_t SAT_HI = sat_max(OUT_W);
  localparam s1_val_t SAT_LO = sat_min(OUT_W);
  localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;

  logic signed [IN_W:0] in_ext;
  logic signed [IN_W:0] in_shift;

`ifdef SAT_NARROW_ROUND_EN
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND = (SHIFT > 0) ? (S1_DW'(1) <<< RND_POS) : '0;
`endif

  // The extra bit keeps the rounding add from overflowing.
  always_comb begin
    in_ext = {in_data[IN_W-1], in_data};
`ifdef SAT_NARROW_ROUND_EN
    in_ext = in_ext + RND;
`endif
    in_shift = in_ext >>> SHIFT;
  end

  logic             s1_valid;
  logic [S1_DW-1:0] s1_data;
  logic             en2;

  sat_narrow_stage #(.W(S1_DW)) u_stage1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tvalid_i (in_valid),
    .s_tdata_i  (in_shift),
    .s_tready_o (in_ready),
    .m_tvalid_o (s1_valid),
    .m_tdata_o  (s1_data),
    .m_tready_i (en2)
  );

  s1_payload_t      s1;
  logic [S2_DW-1:0] s2_in;
  logic [S2_DW-1:0] s2_out;

  always_comb begin
    s1.valid = s1_valid;
    s1.value = s1_val_t'(signed'(s1_data));
    if (s1.value > SAT_HI) begin
      s2_in = {1'b1, OUT_W'(SAT_HI)};
    end else if (s1.value < SAT_LO) begin
      s2_in = {1'b1, OUT_W'(SAT_LO)};
    end else begin
      s2_in = {1'b0, s1.value[OUT_W-1:0]};
    end
  end

  sat_narrow_stage #(.W(S2_DW)) u_stage2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tvalid_i (s1.valid),
    .s_tdata_i  (s2_in),
    .s_tready_o (en2),
    .m_tvalid_o (out_valid),
    .m_tdata_o  (s2_out),
    .m_tready_i (out_ready)
  );

  assign out_sat  = s2_out[OUT_W];
  assign out_data = s2_out[OUT_W-1:0];

  logic                 sat_fire;
  logic                 sticky_q, sticky_d;
  logic [SAT_CNT_W-1:0] cnt_q, cnt_d;

  assign sat_fire = out_valid && out_ready && out_sat;

  // A clipped handshake in the same cycle as clr wins over the clear.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (sat_fire) begin
      sticky_d = 1'b1;
      if (clr) begin
        cnt_d = SAT_CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + SAT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sat_sticky = sticky_q;
  assign sat_count  = cnt_q;

endmodule
